shift_add_mult_seq: RTL and testbench

//  Sequential shift-and-add multiplier core, directly downstream of the two magnitude (two's-complement
//  to positive) stages. Takes unsigned 12-bit magnitudes plus the original operand sign bits.

---
 rtl/shift_add_mult_seq_if.sv | 26 ++
 rtl/shift_add_mult_seq.sv | 92 +++++++++
 tb/tb_shift_add_mult_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_seq_if.sv
// Handshake bundle for the sequential shift-and-add multiplier: operand
// side (in_*, magnitudes, signs) and result side (out_*, product, busy).
interface shift_add_mult_seq_if #(
   parameter int WIDTH = 12
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     x_mag;
   logic [WIDTH-1:0]     y_mag;
   logic                 x_sign;
   logic                 y_sign;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, x_mag, y_mag, x_sign, y_sign, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, x_mag, y_mag, x_sign, y_sign, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier: unsigned magnitudes in, signed 2*WIDTH
// product out after WIDTH add/shift iterations, valid/ready on both sides.
module shift_add_mult_seq #(
   parameter int WIDTH = 12,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   shift_add_mult_seq_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [1:0]           state;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     mplier;
   logic [CNT_W-1:0]     cnt;
   logic                 neg;
   logic                 in_ready_reg;
   logic                 out_valid_reg;
   logic [2*WIDTH-1:0]   product_reg;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   signed_acc;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      acc_next   = acc;
      if (mplier[0]) acc_next = acc + mcand;
      signed_acc = neg ? (~acc + (2*WIDTH)'(1)) : acc;
   end

   // in_ready is registered so it stays low while rst is held and has no
   // combinational dependence on in_valid.
   // NOTE: sequential state uses non-blocking assignments only; every register
   // here is cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         mcand         <= '0;
         acc           <= '0;
         mplier        <= '0;
         cnt           <= '0;
         neg           <= 1'b0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         product_reg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_reg) begin
                  mcand        <= {{WIDTH{1'b0}}, bus.x_mag};
                  mplier       <= bus.y_mag;
                  acc          <= '0;
                  cnt          <= '0;
                  neg          <= bus.x_sign ^ bus.y_sign;
                  in_ready_reg <= 1'b0;
                  state        <= CALC;
               end else begin
                  in_ready_reg <= 1'b1;
               end
            end
            CALC: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) state <= DONE;
            end
            DONE: begin
               // First DONE cycle loads the signed result; it then holds until taken.
               if (!out_valid_reg) begin
                  product_reg   <= signed_acc;
                  out_valid_reg <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.product   = product_reg;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed bench for shift_add_mult_seq: vector table of signed products,
// plus reset, latency, backpressure and mid-calculation abort sequences.
module tb_shift_add_mult_seq;
   localparam int WIDTH = 12;

   typedef struct {
      logic [WIDTH-1:0]   x;
      logic [WIDTH-1:0]   y;
      logic               xs;
      logic               ys;
      logic [2*WIDTH-1:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   pass_cnt;
   int   total_cnt;
   vec_t vecs[8];

   shift_add_mult_seq_if #(.WIDTH(WIDTH)) bus ();

   shift_add_mult_seq #(.WIDTH(WIDTH), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Launches one operation with out_ready high, checks latency, result and release.
   task automatic run_op(input vec_t v, input string name);
      int wait_cyc;
      int lat;
      wait_cyc = 0;
      while (!bus.in_ready && wait_cyc < 50) begin
         @(negedge clk);
         wait_cyc++;
      end
      check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
      bus.x_mag     = v.x;
      bus.y_mag     = v.y;
      bus.x_sign    = v.xs;
      bus.y_sign    = v.ys;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.x_mag    = ~v.x;
      bus.y_mag    = v.y ^ 12'h5A5;
      bus.x_sign   = ~v.xs;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({name, "_latency"}, 32'(lat), 32'd13);
      check({name, "_product"}, 32'(bus.product), 32'(v.exp));
      check({name, "_busy"}, 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      check({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      check({name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      vecs[0] = '{12'd25,   12'd40,   1'b0, 1'b0, 24'h0003E8};
      vecs[1] = '{12'd7,    12'd3,    1'b1, 1'b0, 24'hFFFFEB};
      vecs[2] = '{12'd7,    12'd3,    1'b1, 1'b1, 24'h000015};
      vecs[3] = '{12'h800,  12'h800,  1'b1, 1'b0, 24'hC00000};
      vecs[4] = '{12'd0,    12'hFFF,  1'b1, 1'b0, 24'h000000};
      vecs[5] = '{12'hFFF,  12'hFFF,  1'b0, 1'b0, 24'hFFE001};
      vecs[6] = '{12'hFFF,  12'd1,    1'b0, 1'b1, 24'hFFF001};
      vecs[7] = '{12'hABC,  12'h123,  1'b0, 1'b0, 24'h0C33B4};

      bus.in_valid  = 1'b0;
      bus.x_mag     = '0;
      bus.y_mag     = '0;
      bus.x_sign    = 1'b0;
      bus.y_sign    = 1'b0;
      bus.out_ready = 1'b0;

      // Reset: in_ready low while held, idle outputs after release.
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_product", 32'(bus.product), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: result held for 10 cycles, competing in_valid ignored.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.x_mag     = 12'd100;
      bus.y_mag     = 12'd3;
      bus.x_sign    = 1'b0;
      bus.y_sign    = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clk);
      #1;
      bus.x_mag = 12'd9;
      bus.y_mag = 12'd9;
      begin
         int w;
         w = 0;
         while (!bus.out_valid && w < 40) begin
            @(negedge clk);
            w++;
         end
      end
      check("bp_valid_seen", 32'(bus.out_valid), 32'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("bp_hold_product_%0d", c), 32'(bus.product), 32'd300);
         check($sformatf("bp_hold_valid_%0d", c), 32'(bus.out_valid), 32'd1);
         check($sformatf("bp_in_ready_%0d", c), 32'(bus.in_ready), 32'd0);
      end
      check("bp_busy", 32'(bus.busy), 32'd1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_drop", 32'(bus.out_valid), 32'd0);
      check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      check("bp_product_kept", 32'(bus.product), 32'd300);
      check("bp_busy_clear", 32'(bus.busy), 32'd0);

      // Abort: reset at CALC cycle 5 clears outputs immediately.
      bus.x_mag    = 12'd25;
      bus.y_mag    = 12'd40;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_product", 32'(bus.product), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_no_result", 32'(bus.out_valid), 32'd0);
      run_op('{12'd12, 12'd12, 1'b0, 1'b0, 24'd144}, "post_abort");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
